block_drawer: RTL and testbench
===============================

BLOCK_DRAWER -- requirements
Module: block_drawer

Interface
REQ-001 The module SHALL have parameter BLOCK_SIZE, default 4, giving the block edge in pixels (power of two, 2..8).
REQ-002 The module SHALL have parameter SCREEN_W, default 160, giving the visible width in pixels.
REQ-003 The module SHALL have parameter SCREEN_H, default 120, giving the visible height in pixels.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  draw request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_x  input  8  left pixel column of the row.
REQ-009 req_y  input  7  top pixel line of the row.
REQ-010 req_colour  input  3  RGB colour; 3'b000 erases.
REQ-011 req_len  input  4  number of blocks in the row, 0..15.
REQ-012 vga_x  output  8  pixel column to write.
REQ-013 vga_y  output  7  pixel line to write.
REQ-014 vga_colour  output  3  pixel colour to write.
REQ-015 plot  output  1  write enable for the pixel on vga_x/vga_y/vga_colour.
REQ-016 done  output  1  one-cycle pulse when a request completes.

Function
REQ-017 The module SHALL implement the states IDLE, DRAW and FINISH.
REQ-018 req_ready SHALL be high exactly when the state is IDLE.
REQ-019 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high, and all request inputs SHALL be latched on that edge.
REQ-020 On acceptance with req_len nonzero, the state SHALL move to DRAW with column counter cx=0 and row counter cy=0.
REQ-021 On acceptance with req_len zero, the state SHALL move directly to FINISH and emit no plot.
REQ-022 In DRAW, the block SHALL visit one pixel per cycle in raster order: cx runs 0..len*BLOCK_SIZE-1 (inner), and cy runs 0..BLOCK_SIZE-1 (outer).
REQ-023 For each DRAW cycle, vga_x SHALL be the low 8 bits of (x+cx), vga_y SHALL be the low 7 bits of (y+cy), and vga_colour SHALL be the latched colour.
REQ-024 The sums x+cx and y+cy SHALL be computed at 9 bits.
REQ-025 plot SHALL be high in a DRAW cycle only when the 9-bit x+cx < SCREEN_W and the 9-bit y+cy < SCREEN_H; off-screen pixels SHALL be clipped (plot low) and still consume their cycle.
REQ-026 After the last pixel (cx=len*BLOCK_SIZE-1, cy=BLOCK_SIZE-1), the state SHALL move to FINISH.
REQ-027 DRAW SHALL last exactly len*BLOCK_SIZE*BLOCK_SIZE cycles.
REQ-028 FINISH SHALL last one cycle, during which done is high and plot is low, and SHALL then return to IDLE.
REQ-029 done SHALL be low in every other state.
REQ-030 Request inputs SHALL be ignored while not in IDLE; changes to them mid-draw SHALL not affect the pixels produced.
REQ-031 Back-to-back requests SHALL be supported: a request held valid through FINISH SHALL be accepted on the first IDLE cycle.
REQ-032 The minimum gap between the last plot of one request and the first plot of the next SHALL be 2 cycles (FINISH, IDLE).
REQ-033 In IDLE and FINISH, plot SHALL be low, and vga_x/vga_y/vga_colour SHALL hold their last values.

Reset
REQ-034 When resetn is low, the block SHALL asynchronously enter IDLE.
REQ-035 During reset, cx, cy and the latched registers SHALL be cleared, vga_x=0, vga_y=0, vga_colour=0, plot=0 and done=0.
REQ-036 When resetn asserts mid-DRAW, the block SHALL abort the draw immediately, and no done SHALL be issued for the aborted request.
REQ-037 req_ready SHALL go high on the first rising edge after resetn deasserts.

Verification
REQ-038 Single block: x=8, y=116, colour=3'b101, len=1 -> 16 consecutive plots covering x 8..11 and y 116..119 in raster order, then done on cycle 17, then req_ready high.
REQ-039 Clipping: x=152, y=117, len=3 -> 48 DRAW cycles; plot high only for x 152..159 and y 117..119 (24 pixels); done pulses once.
REQ-040 Zero length: len=0 -> no plot, done one cycle after acceptance, IDLE the cycle after that.
REQ-041 Back-to-back: a draw request (colour=3'b010) followed by an erase (colour=3'b000) held valid -> the second request is accepted 2 cycles after the first request's last plot, and the erase pixels carry colour 3'b000.
REQ-042 Input churn: req_x/req_y/req_colour toggled every cycle during DRAW -> output pixels match the values latched at acceptance.
REQ-043 Reset mid-draw: resetn pulsed low at pixel 5 of a len=2 draw -> plot drops immediately, no done, all outputs 0, and req_ready high after release.

Source files
------------

// File: rtl/block_drawer_if.sv
// Request and pixel-output signal bundle for block_drawer.
// The master modport drives requests; the slave modport is the drawer itself.
interface block_drawer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic [3:0] req_len;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       done;

    modport master (
        output req_valid, req_x, req_y, req_colour, req_len,
        input  req_ready, vga_x, vga_y, vga_colour, plot, done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_colour, req_len,
        output req_ready, vga_x, vga_y, vga_colour, plot, done
    );
endinterface

// File: rtl/block_drawer.sv
// Draws a horizontal row of square blocks one pixel per cycle in raster order,
// clipping pixels that fall outside the visible screen.
module block_drawer #(
    parameter int BLOCK_SIZE = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic          clk,
    input  logic          resetn,
    block_drawer_if.slave bus
);
    localparam int CYW = $clog2(BLOCK_SIZE);

    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    state_t         state;
    logic [7:0]     x_r;
    logic [6:0]     y_r;
    logic [2:0]     colour_r;
    logic [3:0]     len_r;
    logic [7:0]     cx;
    logic [CYW-1:0] cy;

    logic [7:0]     cx_last;
    logic           last_col;
    logic           last_pix;
    logic [7:0]     nx_cx;
    logic [CYW-1:0] nx_cy;
    logic [8:0]     sx;
    logic [8:0]     sy;
    logic [8:0]     ax;
    logic [8:0]     ay;

    function automatic logic on_screen(input logic [8:0] px, input logic [8:0] py);
        return (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));
    endfunction

    assign bus.req_ready = (state == IDLE);

    // Outputs are registered one step ahead: the edge that moves cx/cy also
    // loads the pixel for the new counter values, so they line up with DRAW.
    always_comb begin
        cx_last  = (8'(len_r) << CYW) - 8'd1;
        last_col = (cx == cx_last);
        last_pix = last_col && (cy == CYW'(BLOCK_SIZE - 1));
        nx_cx    = last_col ? '0 : cx + 8'd1;
        nx_cy    = last_col ? cy + CYW'(1) : cy;
        sx       = {1'b0, x_r} + {1'b0, nx_cx};
        sy       = {2'b0, y_r} + 9'(nx_cy);
        ax       = {1'b0, bus.req_x};
        ay       = {2'b0, bus.req_y};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            x_r            <= '0;
            y_r            <= '0;
            colour_r       <= '0;
            len_r          <= '0;
            cx             <= '0;
            cy             <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.plot       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.plot <= 1'b0;
                    bus.done <= 1'b0;
                    if (bus.req_valid) begin
                        x_r      <= bus.req_x;
                        y_r      <= bus.req_y;
                        colour_r <= bus.req_colour;
                        len_r    <= bus.req_len;
                        cx       <= '0;
                        cy       <= '0;
                        if (bus.req_len != 4'd0) begin
                            state          <= DRAW;
                            bus.vga_x      <= bus.req_x;
                            bus.vga_y      <= bus.req_y;
                            bus.vga_colour <= bus.req_colour;
                            bus.plot       <= on_screen(ax, ay);
                        end else begin
                            state    <= FINISH;
                            bus.done <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (last_pix) begin
                        state    <= FINISH;
                        bus.plot <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        cx             <= nx_cx;
                        cy             <= nx_cy;
                        bus.vga_x      <= sx[7:0];
                        bus.vga_y      <= sy[6:0];
                        bus.vga_colour <= colour_r;
                        bus.plot       <= on_screen(sx, sy);
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    bus.plot <= 1'b0;
                    bus.done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.plot <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_block_drawer.sv
// Directed bench for block_drawer: single block, clipping, zero length,
// back-to-back erase, input churn and reset during a draw.
module tb_block_drawer;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    block_drawer_if bus();

    block_drawer #(
        .BLOCK_SIZE(4),
        .SCREEN_W  (160),
        .SCREEN_H  (120)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input int x, input int y, input int c, input int len);
        bus.req_valid  = 1'b1;
        bus.req_x      = 8'(x);
        bus.req_y      = 7'(y);
        bus.req_colour = 3'(c);
        bus.req_len    = 4'(len);
    endtask

    initial begin
        int plots;
        int ex;
        int ey;
        logic exp_plot;

        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        bus.req_len    = '0;

        // Reset state
        tick();
        tick();
        check("rst_plot",   32'(bus.plot), 0);
        check("rst_done",   32'(bus.done), 0);
        check("rst_vga_x",  32'(bus.vga_x), 0);
        check("rst_vga_y",  32'(bus.vga_y), 0);
        check("rst_colour", 32'(bus.vga_colour), 0);
        resetn = 1'b1;
        tick();
        check("rst_ready", 32'(bus.req_ready), 1);

        // Single block at the bottom edge of the screen
        request(8, 116, 3'b101, 1);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("blk_plot",   32'(bus.plot), 1);
            check("blk_x",      32'(bus.vga_x), 32'(8 + i % 4));
            check("blk_y",      32'(bus.vga_y), 32'(116 + i / 4));
            check("blk_colour", 32'(bus.vga_colour), 5);
            check("blk_done",   32'(bus.done), 0);
            check("blk_ready",  32'(bus.req_ready), 0);
            tick();
        end
        check("blk_fin_done", 32'(bus.done), 1);
        check("blk_fin_plot", 32'(bus.plot), 0);
        check("blk_fin_x",    32'(bus.vga_x), 11);
        check("blk_fin_y",    32'(bus.vga_y), 119);
        tick();
        check("blk_idle_ready", 32'(bus.req_ready), 1);
        check("blk_idle_done",  32'(bus.done), 0);

        // Clipping at the bottom-right corner
        request(152, 117, 3'b011, 3);
        tick();
        bus.req_valid = 1'b0;
        plots = 0;
        for (int i = 0; i < 48; i++) begin
            ex = 152 + i % 12;
            ey = 117 + i / 12;
            exp_plot = (ex < 160) && (ey < 120);
            check("clip_plot", 32'(bus.plot), 32'(exp_plot));
            check("clip_x",    32'(bus.vga_x), 32'(ex % 256));
            check("clip_y",    32'(bus.vga_y), 32'(ey % 128));
            check("clip_done", 32'(bus.done), 0);
            if (bus.plot) plots++;
            tick();
        end
        check("clip_count",    32'(plots), 24);
        check("clip_fin_done", 32'(bus.done), 1);
        tick();
        check("clip_idle_done",  32'(bus.done), 0);
        check("clip_idle_ready", 32'(bus.req_ready), 1);

        // Zero length
        request(30, 30, 3'b111, 0);
        tick();
        bus.req_valid = 1'b0;
        check("zero_done",  32'(bus.done), 1);
        check("zero_plot",  32'(bus.plot), 0);
        check("zero_ready", 32'(bus.req_ready), 0);
        tick();
        check("zero_idle_ready", 32'(bus.req_ready), 1);
        check("zero_idle_done",  32'(bus.done), 0);
        check("zero_idle_plot",  32'(bus.plot), 0);

        // Back-to-back draw then erase held valid throughout
        request(0, 0, 3'b010, 1);
        tick();
        request(20, 10, 3'b000, 1);
        for (int i = 0; i < 16; i++) begin
            check("b2b_a_plot",   32'(bus.plot), 1);
            check("b2b_a_x",      32'(bus.vga_x), 32'(i % 4));
            check("b2b_a_y",      32'(bus.vga_y), 32'(i / 4));
            check("b2b_a_colour", 32'(bus.vga_colour), 2);
            tick();
        end
        check("b2b_fin_done",  32'(bus.done), 1);
        check("b2b_fin_ready", 32'(bus.req_ready), 0);
        check("b2b_fin_plot",  32'(bus.plot), 0);
        tick();
        check("b2b_idle_ready", 32'(bus.req_ready), 1);
        check("b2b_idle_plot",  32'(bus.plot), 0);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("b2b_e_plot",   32'(bus.plot), 1);
            check("b2b_e_x",      32'(bus.vga_x), 32'(20 + i % 4));
            check("b2b_e_y",      32'(bus.vga_y), 32'(10 + i / 4));
            check("b2b_e_colour", 32'(bus.vga_colour), 0);
            tick();
        end
        check("b2b_e_done", 32'(bus.done), 1);
        tick();

        // Input churn during a draw
        request(40, 50, 3'b110, 2);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("churn_plot",   32'(bus.plot), 1);
            check("churn_x",      32'(bus.vga_x), 32'(40 + i % 8));
            check("churn_y",      32'(bus.vga_y), 32'(50 + i / 8));
            check("churn_colour", 32'(bus.vga_colour), 6);
            bus.req_x      = 8'($urandom);
            bus.req_y      = 7'($urandom);
            bus.req_colour = 3'($urandom);
            tick();
        end
        check("churn_done", 32'(bus.done), 1);
        tick();

        // Reset at pixel 5 of a two-block draw
        request(0, 0, 3'b111, 2);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rmid_pre_plot", 32'(bus.plot), 1);
        check("rmid_pre_x",    32'(bus.vga_x), 5);
        resetn = 1'b0;
        #1;
        check("rmid_plot",   32'(bus.plot), 0);
        check("rmid_done",   32'(bus.done), 0);
        check("rmid_x",      32'(bus.vga_x), 0);
        check("rmid_y",      32'(bus.vga_y), 0);
        check("rmid_colour", 32'(bus.vga_colour), 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("rmid_ready", 32'(bus.req_ready), 1);
        for (int i = 0; i < 4; i++) begin
            check("rmid_no_done", 32'(bus.done), 0);
            check("rmid_no_plot", 32'(bus.plot), 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
